alu_seq: RTL and testbench



---
 rtl/alu_seq.sv | 109 ++++++++++
 tb/tb_alu_seq.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencer for the 8-bit ALU: 4x8 register file, carry flag, optional zero flag (ALU_SEQ_ZFLAG_EN).
// Latency: ALU op done 3 cycles after accept, load done 1 cycle after accept.
// Backpressure: instr_ready only in IDLE; instr_valid while busy is ignored.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic             instr_ld,
    input  logic [2:0]       instr_op,
    input  logic [AW-1:0]    instr_rd,
    input  logic [AW-1:0]    instr_rs,
    input  logic [WIDTH-1:0] instr_imm,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    output logic             done,
    output logic             carry,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic             zero,
`endif
    input  logic [AW-1:0]    dbg_addr,
    output logic [WIDTH-1:0] dbg_data
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        WRITE   = 2'd3
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   regs [NREGS];
    logic               lat_ld;
    logic [2:0]         lat_op;
    logic [AW-1:0]      lat_rd;
    logic [WIDTH-1:0]   lat_imm;
    logic [WIDTH-1:0]   result;
    logic               cflag_next;

    assign instr_ready = (state == IDLE);
    assign dbg_data    = regs[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            lat_ld     <= 1'b0;
            lat_op     <= '0;
            lat_rd     <= '0;
            lat_imm    <= '0;
            result     <= '0;
            cflag_next <= 1'b0;
            carry      <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            done       <= 1'b0;
`ifdef ALU_SEQ_ZFLAG_EN
            zero       <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        lat_ld  <= instr_ld;
                        lat_op  <= instr_op;
                        lat_rd  <= instr_rd;
                        lat_imm <= instr_imm;
                        if (instr_ld) begin
                            state <= WRITE;
                        end else begin
                            // Operands read here, so rd == rs sees pre-write values.
                            alu_a  <= regs[instr_rd];
                            alu_b  <= regs[instr_rs];
                            alu_op <= instr_op;
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    result <= alu_out;
                    if (lat_op == 3'd0) cflag_next <= alu_carry;
                    state <= WRITE;
                end
                WRITE: begin
                    regs[lat_rd] <= lat_ld ? lat_imm : result;
                    if (!lat_ld && lat_op == 3'd0) carry <= cflag_next;
`ifdef ALU_SEQ_ZFLAG_EN
                    if (!lat_ld) zero <= (result == '0);
`endif
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq with a behavioural ALU attached to its ALU port.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       instr_valid;
    logic       instr_ready;
    logic       instr_ld;
    logic [2:0] instr_op;
    logic [1:0] instr_rd;
    logic [1:0] instr_rs;
    logic [7:0] instr_imm;
    logic [2:0] alu_op;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       done;
    logic       carry;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       zero;
`endif
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_ld    (instr_ld),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_rs    (instr_rs),
        .instr_imm   (instr_imm),
        .alu_op      (alu_op),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_out     (alu_out),
        .alu_carry   (alu_carry),
        .done        (done),
        .carry       (carry),
`ifdef ALU_SEQ_ZFLAG_EN
        .zero        (zero),
`endif
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always_comb begin
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_op)
            3'd0:    {alu_carry, alu_out} = {1'b0, alu_a} + {1'b0, alu_b};
            3'd1:    alu_out = alu_a - alu_b;
            3'd2:    alu_out = alu_a & alu_b;
            3'd3:    alu_out = alu_a | alu_b;
            default: alu_out = ~alu_a;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        check(tag, {24'h0, dbg_data}, {24'h0, exp});
    endtask

    // Issue one instruction and check the edges from accept to the done pulse.
    task automatic exec(input string tag, input logic ld, input logic [2:0] op,
                        input logic [1:0] rd, input logic [1:0] rs,
                        input logic [7:0] imm, input int exp_lat);
        int lat;
        @(negedge clk);
        instr_ld = ld; instr_op = op; instr_rd = rd; instr_rs = rs; instr_imm = imm;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = 99;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b0; instr_valid = 1'b0; instr_ld = 1'b0; instr_op = 3'd0;
        instr_rd = 2'd0; instr_rs = 2'd0; instr_imm = 8'h00; dbg_addr = 2'd0;
        #1;
        check("rst_ready", {31'h0, instr_ready}, 1);
        check("rst_done", {31'h0, done}, 0);
        check("rst_carry", {31'h0, carry}, 0);
        check("rst_alu_a", {24'h0, alu_a}, 0);
        #11 rst_n = 1'b1;
        for (int r = 0; r < 4; r++) check_reg("rst_reg", 2'(r), 8'h00);

        // Loads then ADD without carry
        exec("ld_r0", 1'b1, 3'd0, 2'd0, 2'd0, 8'h0F, 1);
        exec("ld_r1", 1'b1, 3'd0, 2'd1, 2'd0, 8'h01, 1);
        check_reg("ld_r0_val", 2'd0, 8'h0F);
        exec("add01", 1'b0, 3'd0, 2'd0, 2'd1, 8'h00, 3);
        check_reg("add01_val", 2'd0, 8'h10);
        check("add01_carry", {31'h0, carry}, 0);

        // ADD with carry out, then SUB wraps and holds carry
        exec("ld_r2", 1'b1, 3'd0, 2'd2, 2'd0, 8'hFF, 1);
        exec("add21", 1'b0, 3'd0, 2'd2, 2'd1, 8'h00, 3);
        check_reg("add21_val", 2'd2, 8'h00);
        check("add21_carry", {31'h0, carry}, 1);
`ifdef ALU_SEQ_ZFLAG_EN
        check("add21_zero", {31'h0, zero}, 1);
`endif
        exec("sub21", 1'b0, 3'd1, 2'd2, 2'd1, 8'h00, 3);
        check_reg("sub21_val", 2'd2, 8'hFF);
        check("sub21_carry", {31'h0, carry}, 1);
`ifdef ALU_SEQ_ZFLAG_EN
        check("sub21_zero", {31'h0, zero}, 0);
`endif

        // Logic ops leave carry alone
        exec("ld_r0b", 1'b1, 3'd0, 2'd0, 2'd0, 8'h0F, 1);
        exec("and01", 1'b0, 3'd2, 2'd0, 2'd1, 8'h00, 3);
        check_reg("and01_val", 2'd0, 8'h01);
        exec("ld_r0c", 1'b1, 3'd0, 2'd0, 2'd0, 8'h0F, 1);
        exec("or01", 1'b0, 3'd3, 2'd0, 2'd1, 8'h00, 3);
        check_reg("or01_val", 2'd0, 8'h0F);
        exec("not0", 1'b0, 3'd4, 2'd0, 2'd1, 8'h00, 3);
        check_reg("not0_val", 2'd0, 8'hF0);
        check("logic_carry", {31'h0, carry}, 1);
        check("hold_alu_a", {24'h0, alu_a}, 32'h0F);
        check("hold_alu_op", {29'h0, alu_op}, 4);

        // rd == rs uses pre-write operand; ADD clears carry
        exec("ld_r3", 1'b1, 3'd0, 2'd3, 2'd0, 8'h05, 1);
        exec("add33", 1'b0, 3'd0, 2'd3, 2'd3, 8'h00, 3);
        check_reg("add33_val", 2'd3, 8'h0A);
        check("add33_carry", {31'h0, carry}, 0);

        // Backpressure: valid held high with changing fields during ADD
        exec("ld_r0d", 1'b1, 3'd0, 2'd0, 2'd0, 8'h0F, 1);
        @(negedge clk);
        instr_ld = 1'b0; instr_op = 3'd0; instr_rd = 2'd0; instr_rs = 2'd1; instr_imm = 8'h00;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_ld = 1'b1; instr_rd = 2'd0; instr_imm = 8'h55;
        check("bp_busy", {31'h0, instr_ready}, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("bp_nodone", {31'h0, done}, 0);
        @(posedge clk); #1;
        check("bp_done1", {31'h0, done}, 1);
        check("bp_ready", {31'h0, instr_ready}, 1);
        check_reg("bp_r0", 2'd0, 8'h10);
        instr_rd = 2'd3; instr_imm = 8'hAA;
        @(posedge clk); #1;
        check("bp_accept2", {31'h0, instr_ready}, 0);
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check("bp_done2", {31'h0, done}, 1);
        check_reg("bp_r3", 2'd3, 8'hAA);
        check_reg("bp_r0_kept", 2'd0, 8'h10);

        // Reset during CAPTURE aborts the operation
        exec("ld_r2b", 1'b1, 3'd0, 2'd2, 2'd0, 8'h33, 1);
        @(negedge clk);
        instr_ld = 1'b0; instr_op = 3'd0; instr_rd = 2'd2; instr_rs = 2'd1;
        instr_valid = 1'b1;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_ready", {31'h0, instr_ready}, 1);
        check("abort_done", {31'h0, done}, 0);
        check("abort_alu_a", {24'h0, alu_a}, 0);
        check_reg("abort_r2", 2'd2, 8'h00);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        check("abort_nodone", dcount, 0);
        exec("ld_after", 1'b1, 3'd0, 2'd2, 2'd0, 8'h77, 1);
        check_reg("ld_after_val", 2'd2, 8'h77);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
